ic_eq_bvshl_checker: RTL and testbench

Sequential exhaustive checker that sits directly downstream of the combinational Skolem-function blocks for the left-shift equality invertibility condition. It enumerates every (s, t) pair of W-bit vectors and drives them to the Skolem blocks, which return a W-bit candidate witness. For each pair it decides by brute-force search whether a witness exists (the IC), then checks that the returned witness satisfies (x << s) == t whenever the IC holds. It reports pass/fail counts and the first failing triple.

---
 rtl/ic_eq_bvshl_checker_if.sv | 50 +++++
 rtl/ic_eq_bvshl_checker.sv | 148 ++++++++++++++
 tb/tb_ic_eq_bvshl_checker.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ic_eq_bvshl_checker_if.sv
// Interface between the exhaustive left-shift equality checker and the outside world.
// The checker (master) drives s/t toward the Skolem blocks, receives the witness,
// and publishes its status and results. The slave side is the Skolem blocks plus
// whoever issues start and reads results.
interface ic_eq_bvshl_checker_if #(
   parameter int W = 4
) ();
   logic           start;
   logic [W-1:0]   sk_s;
   logic [W-1:0]   sk_t;
   logic [W-1:0]   sk_x;
   logic           busy;
   logic           done;
   logic           pass;
   logic [2*W:0]   ic_count;
   logic [2*W:0]   fail_count;
   logic [W-1:0]   fail_s;
   logic [W-1:0]   fail_t;
   logic [W-1:0]   fail_x;

   modport master (
      input  start,
      input  sk_x,
      output sk_s,
      output sk_t,
      output busy,
      output done,
      output pass,
      output ic_count,
      output fail_count,
      output fail_s,
      output fail_t,
      output fail_x
   );

   modport slave (
      output start,
      output sk_x,
      input  sk_s,
      input  sk_t,
      input  busy,
      input  done,
      input  pass,
      input  ic_count,
      input  fail_count,
      input  fail_s,
      input  fail_t,
      input  fail_x
   );
endinterface

// File: rtl/ic_eq_bvshl_checker.sv
// Exhaustive checker for the Skolem witness of (x << s) == t.
// Sweeps every {t, s} pair, brute-forces whether any x satisfies the equation,
// and checks that the witness returned by the Skolem blocks is correct whenever
// one exists. Reports pair counts and the first failing triple.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// LATCH  | sk_s/sk_t settled for a full cycle; capture the witness
// SEARCH | one candidate x per cycle, looking for any solution
// CHECK  | update counts, capture first failure, advance or finish
// DONE   | results valid; start re-sweeps from index 0
module ic_eq_bvshl_checker #(
   parameter int W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   ic_eq_bvshl_checker_if.master    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_SEARCH,
      S_CHECK,
      S_DONE
   } state_t;

   state_t          state;
   logic [2*W-1:0]  idx;
   logic [W-1:0]    cand;
   logic [W-1:0]    wit;
   logic            ic;
   logic            busy;
   logic            done;
   logic            pass;
   logic [2*W:0]    ic_count;
   logic [2*W:0]    fail_count;
   logic [W-1:0]    fail_s;
   logic [W-1:0]    fail_t;
   logic [W-1:0]    fail_x;

   logic [W-1:0]    cur_s;
   logic [W-1:0]    cur_t;
   logic            cand_hit;
   logic            wit_ok;

   // Shift amounts at or beyond W push every bit out, giving 0, which is
   // exactly the truncating semantics wanted here.
   function automatic logic [W-1:0] shl(input logic [W-1:0] v, input logic [W-1:0] amt);
      shl = v << amt;
   endfunction

   // The pair index doubles as the registered s/t drive: s in the low half.
   assign cur_s    = idx[W-1:0];
   assign cur_t    = idx[2*W-1:W];
   assign cand_hit = (shl(cand, cur_s) == cur_t);
   assign wit_ok   = !ic || (shl(wit, cur_s) == cur_t);

   assign bus.sk_s       = cur_s;
   assign bus.sk_t       = cur_t;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.pass       = pass;
   assign bus.ic_count   = ic_count;
   assign bus.fail_count = fail_count;
   assign bus.fail_s     = fail_s;
   assign bus.fail_t     = fail_t;
   assign bus.fail_x     = fail_x;

   // Sweep sequencer, search and result bookkeeping with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         cand       <= '0;
         wit        <= '0;
         ic         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         ic_count   <= '0;
         fail_count <= '0;
         fail_s     <= '0;
         fail_t     <= '0;
         fail_x     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  idx        <= '0;
                  ic_count   <= '0;
                  fail_count <= '0;
                  fail_s     <= '0;
                  fail_t     <= '0;
                  fail_x     <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  state      <= S_LATCH;
               end
            end
            S_LATCH: begin
               wit   <= bus.sk_x;
               cand  <= '0;
               state <= S_SEARCH;
            end
            S_SEARCH: begin
               if (cand_hit) begin
                  ic    <= 1'b1;
                  state <= S_CHECK;
               end else if (&cand) begin
                  ic    <= 1'b0;
                  state <= S_CHECK;
               end else begin
                  cand <= cand + 1'b1;
               end
            end
            S_CHECK: begin
               if (ic) begin
                  ic_count <= ic_count + 1'b1;
               end
               if (!wit_ok) begin
                  fail_count <= fail_count + 1'b1;
                  if (fail_count == '0) begin
                     fail_s <= cur_s;
                     fail_t <= cur_t;
                     fail_x <= wit;
                  end
               end
               if (&idx) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_count == '0) && wit_ok;
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_LATCH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ic_eq_bvshl_checker.sv
// Scoreboard bench for ic_eq_bvshl_checker with W=4: directed sweeps using
// ideal, stuck-at-zero and single-corruption witness models.
module tb_ic_eq_bvshl_checker;
   localparam int W = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   mode;
   int   chg;

   typedef struct {
      int ic;
      int fl;
      int ps;
      int fs;
      int ft;
      int fx;
   } exp_t;

   exp_t sb_q[$];

   ic_eq_bvshl_checker_if #(.W(W)) bus ();

   ic_eq_bvshl_checker #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Skolem block models: 0 ideal, 1 stuck at zero, 2 ideal but wrong at s=2,t=8.
   always_comb begin
      bus.sk_x = '0;
      if (mode != 1) begin
         if (bus.sk_s < W) bus.sk_x = bus.sk_t >> bus.sk_s;
         if (mode == 2 && bus.sk_s == 4'd2 && bus.sk_t == 4'd8) bus.sk_x = 4'd3;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic push_exp(input int ic, input int fl, input int ps,
                           input int fs, input int ft, input int fx);
      exp_t e;
      e.ic = ic; e.fl = fl; e.ps = ps; e.fs = fs; e.ft = ft; e.fx = fx;
      sb_q.push_back(e);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_timeout", {31'd0, seen}, 32'd1);
   endtask

   task automatic wait_idx(input int target);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk);
         #1;
         if (int'({bus.sk_t, bus.sk_s}) == target) begin
            seen = 1'b1;
            break;
         end
      end
      chk("idx_timeout", {31'd0, seen}, 32'd1);
   endtask

   // Edges until the current {t,s} drive moves on.
   task automatic count_pair(input int cur, output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (int'({bus.sk_t, bus.sk_s}) != cur) break;
      end
   endtask

   // Counts s/t changes inside a sweep; a fast or repeated change shows up here.
   initial begin
      logic [2*W-1:0] sk_q;
      logic           busy_q;
      sk_q   = '0;
      busy_q = 1'b0;
      chg    = 0;
      forever begin
         @(negedge clk);
         if (bus.busy && !busy_q) chg = 0;
         else if (bus.busy && busy_q && {bus.sk_t, bus.sk_s} != sk_q) chg++;
         sk_q   = {bus.sk_t, bus.sk_s};
         busy_q = bus.busy;
      end
   end

   // Result monitor: every rising done pops one expected record.
   initial begin
      logic done_q;
      exp_t e;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done && !done_q) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("ic_count",   32'(bus.ic_count),   32'(e.ic));
               chk("fail_count", 32'(bus.fail_count), 32'(e.fl));
               chk("pass",       32'(bus.pass),       32'(e.ps));
               chk("fail_s",     32'(bus.fail_s),     32'(e.fs));
               chk("fail_t",     32'(bus.fail_t),     32'(e.ft));
               chk("fail_x",     32'(bus.fail_x),     32'(e.fx));
            end
         end
         done_q = bus.done;
      end
   end

   initial begin
      int n;
      total     = 0;
      bad       = 0;
      mode      = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_sk_s",       32'(bus.sk_s),       32'd0);
      chk("rst_sk_t",       32'(bus.sk_t),       32'd0);
      chk("rst_busy",       32'(bus.busy),       32'd0);
      chk("rst_done",       32'(bus.done),       32'd0);
      chk("rst_pass",       32'(bus.pass),       32'd0);
      chk("rst_ic_count",   32'(bus.ic_count),   32'd0);
      chk("rst_fail_count", 32'(bus.fail_count), 32'd0);
      chk("rst_fail_x",     32'(bus.fail_x),     32'd0);

      // Ideal witness, with latency checks on the way.
      mode = 0;
      push_exp(42, 0, 1, 0, 0, 0);
      pulse_start();
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      count_pair(0, n);
      chk("lat_pair_0_0", 32'(n), 32'd3);
      wait_idx(17);
      count_pair(17, n);
      chk("lat_pair_1_1", 32'(n), 32'd18);
      wait_done();
      chk("sweep1_changes", 32'(chg), 32'd255);
      chk("busy_in_done", 32'(bus.busy), 32'd0);

      // Stuck-at-zero witness.
      mode = 1;
      push_exp(42, 26, 0, 0, 1, 0);
      pulse_start();
      wait_done();

      // One corrupted answer at s=2, t=8.
      mode = 2;
      push_exp(42, 1, 0, 2, 8, 3);
      pulse_start();
      wait_done();

      // Starts while busy are ignored; reset mid-sweep drops everything.
      mode = 0;
      pulse_start();
      wait_idx(50);
      pulse_start();
      pulse_start();
      wait_idx(100);
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.start = 1'b0;
      chk("midrst_busy",     32'(bus.busy),     32'd0);
      chk("midrst_sk",       32'({bus.sk_t, bus.sk_s}), 32'd0);
      chk("midrst_ic_count", 32'(bus.ic_count), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_still_idle", 32'(bus.busy), 32'd0);
      push_exp(42, 0, 1, 0, 0, 0);
      pulse_start();
      wait_idx(60);
      pulse_start();
      wait_done();
      chk("sweep_rst_changes", 32'(chg), 32'd255);

      // Back-to-back sweep from DONE.
      push_exp(42, 0, 1, 0, 0, 0);
      pulse_start();
      chk("b2b_done_clear", 32'(bus.done),     32'd0);
      chk("b2b_ic_clear",   32'(bus.ic_count), 32'd0);
      chk("b2b_busy",       32'(bus.busy),     32'd1);
      wait_done();

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
